// File: rtl/seq_nr_divider_if.sv
// Handshake and operand/result bundle for seq_nr_divider.
// SEQ_NR_DIVIDER_SIGNED_DIV_EN adds the is_signed request field.
interface seq_nr_divider_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
`ifdef SEQ_NR_DIVIDER_SIGNED_DIV_EN
    logic             is_signed;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
`ifdef SEQ_NR_DIVIDER_SIGNED_DIV_EN
        output is_signed,
`endif
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
`ifdef SEQ_NR_DIVIDER_SIGNED_DIV_EN
        input  is_signed,
`endif
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_nr_divider.sv
// Self-sequenced non-restoring divider with start/busy/done handshake and divide-by-zero flag.
// Optional signed mode: define SEQ_NR_DIVIDER_SIGNED_DIV_EN.
module seq_nr_divider #(
    parameter int WIDTH = 8
) (
    input logic            clk,
    input logic            reset,
    seq_nr_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, ITER, CORRECT, DONE} state_t;

    state_t           state, state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   r_q;
    logic [WIDTH-1:0] q_q, d_q;
    logic [WIDTH-1:0] quot_q, rem_q;
    logic             dz_q;

    logic [WIDTH:0]   d_ext, r_shift, r_step, r_fix;
    logic [WIDTH-1:0] a_mag, b_mag, quot_fin, rem_fin;
    logic             accept, is_zero;

`ifdef SEQ_NR_DIVIDER_SIGNED_DIV_EN
    logic neg_quot_q, neg_rem_q;
    logic sign_a, sign_b;
`endif

    assign accept  = (state == IDLE) && bus.start;
    assign is_zero = (bus.divisor == '0);

    // Operand magnitudes are loaded so the iteration itself is always unsigned
    always_comb begin
`ifdef SEQ_NR_DIVIDER_SIGNED_DIV_EN
        sign_a = bus.is_signed & bus.dividend[WIDTH-1];
        sign_b = bus.is_signed & bus.divisor[WIDTH-1];
        a_mag  = sign_a ? -bus.dividend : bus.dividend;
        b_mag  = sign_b ? -bus.divisor  : bus.divisor;
`else
        a_mag  = bus.dividend;
        b_mag  = bus.divisor;
`endif
    end

    always_comb begin
        d_ext   = {1'b0, d_q};
        r_shift = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
        r_step  = r_q[WIDTH] ? (r_shift + d_ext) : (r_shift - d_ext);
        r_fix   = r_q[WIDTH] ? (r_q + d_ext) : r_q;
`ifdef SEQ_NR_DIVIDER_SIGNED_DIV_EN
        quot_fin = neg_quot_q ? -q_q : q_q;
        rem_fin  = neg_rem_q  ? -r_fix[WIDTH-1:0] : r_fix[WIDTH-1:0];
`else
        quot_fin = q_q;
        rem_fin  = r_fix[WIDTH-1:0];
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = is_zero ? DONE : ITER;
            ITER:    if (cnt == CW'(WIDTH - 1)) state_next = CORRECT;
            CORRECT: state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            r_q    <= '0;
            q_q    <= '0;
            d_q    <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            dz_q   <= 1'b0;
`ifdef SEQ_NR_DIVIDER_SIGNED_DIV_EN
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (accept) begin
                    if (is_zero) begin
                        quot_q <= '1;
                        rem_q  <= bus.dividend;
                        dz_q   <= 1'b1;
                    end else begin
                        r_q <= '0;
                        q_q <= a_mag;
                        d_q <= b_mag;
                        cnt <= '0;
`ifdef SEQ_NR_DIVIDER_SIGNED_DIV_EN
                        neg_quot_q <= sign_a ^ sign_b;
                        neg_rem_q  <= sign_a;
`endif
                    end
                end
                ITER: begin
                    r_q <= r_step;
                    q_q <= {q_q[WIDTH-2:0], ~r_step[WIDTH]};
                    cnt <= cnt + 1'b1;
                end
                CORRECT: begin
                    r_q    <= r_fix;
                    quot_q <= quot_fin;
                    rem_q  <= rem_fin;
                    dz_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = (state != IDLE);
    assign bus.done        = (state == DONE);
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dz_q;
endmodule
